// File: rtl/usart_tx.sv
// Asynchronous-serial transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Every bit is held for BAUD_DIV clocks; a word is taken on a valid/ready handshake in IDLE.
module usart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 868,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  s_rst_n_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_q;
    logic                  stop_q;
    logic                  tx_q;
    logic                  done_q;
    logic                  baud_end;
    logic                  accept;

    function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign baud_end  = (baud_q == BAUD_LAST);
    assign s_ready_o = (state_q == IDLE) && s_rst_n_i;
    assign accept    = s_valid_i && s_ready_o;
    assign busy_o    = (state_q != IDLE);
    assign tx_o      = tx_q;
    assign done_o    = done_q;

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // The baud counter only runs inside a frame; it wraps to 0 on the last clock of a bit.
            if (state_q != IDLE) begin
                baud_q <= baud_end ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q  <= s_data_i;
                        parity_q <= frame_parity(s_data_i);
                        baud_q   <= '0;
                        bit_q    <= '0;
                        stop_q   <= 1'b0;
                        tx_q     <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_q == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (stop_q == STOP_LAST) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: four instances cover plain 8N1, even/odd parity and two stop bits.
// Expected line levels come from a frame model computed from bit position and word contents.
module tb_usart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic [3:0] valid;
    logic [3:0] rdy_w, tx_w, busy_w, done_w;

    int   total = 0;
    int   bad   = 0;
    logic obs_tx[128], obs_busy[128], obs_done[128], obs_rdy[128];
    logic rdy_pre;

    always #5 clk = ~clk;

    usart_tx #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
        .clk_i(clk), .s_rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(valid[0]),
        .s_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
    usart_tx #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk_i(clk), .s_rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(valid[1]),
        .s_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
    usart_tx #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk_i(clk), .s_rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(valid[2]),
        .s_ready_o(rdy_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));
    usart_tx #(.DATA_WIDTH(8), .BAUD_DIV(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
        .clk_i(clk), .s_rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(valid[3]),
        .s_ready_o(rdy_w[3]), .tx_o(tx_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]));

    function automatic int cfg_bd(input int i);
        return (i == 3) ? 2 : 4;
    endfunction
    function automatic int cfg_pe(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_odd(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int frame_len(input int i);
        return (1 + 8 + cfg_pe(i) + cfg_sb(i)) * cfg_bd(i);
    endfunction

    // Line level t clocks after the handshake edge of a single frame.
    function automatic logic model_bit(input int i, input logic [7:0] d, input int t);
        int b;
        int ones;
        b    = t / cfg_bd(i);
        ones = 0;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (cfg_pe(i) == 1 && b == 9) begin
            for (int k = 0; k < 8; k++) ones += int'(d[k]);
            return ((ones + cfg_odd(i)) % 2) == 1;
        end
        return 1'b1;
    endfunction

    // Trace model for one frame, or two back-to-back frames separated by one idle clock.
    function automatic logic exp_tx(input int i, input logic [7:0] d1, input logic [7:0] d2, input int j);
        int len;
        len = frame_len(i);
        if (j < len) return model_bit(i, d1, j);
        if (j == len) return 1'b1;
        if (j <= 2 * len) return model_bit(i, d2, j - len - 1);
        return 1'b1;
    endfunction
    function automatic logic exp_done(input int i, input int j);
        return (j == frame_len(i)) || (j == 2 * frame_len(i) + 1);
    endfunction

    task automatic drive_frame(input int inst, input logic [7:0] d1, input logic [7:0] d2,
                               input int n, input bit hold, input bit scramble);
        @(negedge clk);
        s_data      = d1;
        valid[inst] = 1'b1;
        rdy_pre     = rdy_w[inst];
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            obs_tx[j]   = tx_w[inst];
            obs_busy[j] = busy_w[inst];
            obs_done[j] = done_w[inst];
            obs_rdy[j]  = rdy_w[inst];
            if (j == 0) begin
                if (hold) s_data = d2;
                else      valid[inst] = 1'b0;
            end
            if (scramble && j < n - 1) begin
                s_data      = 8'($urandom);
                valid[inst] = 1'($urandom);
            end
        end
        valid[inst] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = '0;
        s_data = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx_w[i] !== 1'b1) begin bad++; $display("FAIL reset_tx inst=%0d got=%b want=1", i, tx_w[i]); end
            total++;
            if (busy_w[i] !== 1'b0) begin bad++; $display("FAIL reset_busy inst=%0d got=%b want=0", i, busy_w[i]); end
            total++;
            if (done_w[i] !== 1'b0) begin bad++; $display("FAIL reset_done inst=%0d got=%b want=0", i, done_w[i]); end
            total++;
            if (rdy_w[i] !== 1'b0) begin bad++; $display("FAIL reset_ready_low inst=%0d got=%b want=0", i, rdy_w[i]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdy_w[i] !== 1'b1) begin bad++; $display("FAIL reset_ready_after inst=%0d got=%b want=1", i, rdy_w[i]); end
        end
    endtask

    task automatic test_frame_a5();
        logic [9:0] seq;
        seq = 10'b1101001010;
        drive_frame(0, 8'hA5, 8'h00, 41, 1'b0, 1'b0);
        total++;
        if (rdy_pre !== 1'b1) begin bad++; $display("FAIL a5_ready got=%b want=1", rdy_pre); end
        for (int j = 0; j < 41; j++) begin
            total++;
            if (j < 40 && obs_tx[j] !== seq[j/4]) begin
                bad++; $display("FAIL a5_tx t=%0d got=%b want=%b", j, obs_tx[j], seq[j/4]);
            end
            total++;
            if (obs_done[j] !== (j == 40)) begin
                bad++; $display("FAIL a5_done t=%0d got=%b want=%b", j, obs_done[j], (j == 40));
            end
            total++;
            if (obs_busy[j] !== (j < 40)) begin
                bad++; $display("FAIL a5_busy t=%0d got=%b want=%b", j, obs_busy[j], (j < 40));
            end
        end
    endtask

    task automatic test_random_frames();
        for (int r = 0; r < 8; r++) begin
            int         inst;
            int         len;
            logic [7:0] d;
            inst = int'($urandom_range(0, 3));
            d    = 8'($urandom);
            len  = frame_len(inst);
            drive_frame(inst, d, 8'h00, len + 1, 1'b0, 1'b0);
            for (int j = 0; j <= len; j++) begin
                total++;
                if (obs_tx[j] !== exp_tx(inst, d, 8'h00, j)) begin
                    bad++; $display("FAIL rand_tx inst=%0d d=%h t=%0d got=%b want=%b", inst, d, j, obs_tx[j], exp_tx(inst, d, 8'h00, j));
                end
                total++;
                if (obs_done[j] !== exp_done(inst, j)) begin
                    bad++; $display("FAIL rand_done inst=%0d t=%0d got=%b want=%b", inst, j, obs_done[j], exp_done(inst, j));
                end
            end
        end
    endtask

    task automatic test_parity();
        for (int inst = 1; inst <= 2; inst++) begin
            logic want_par;
            want_par = (inst == 1) ? 1'b1 : 1'b0;
            drive_frame(inst, 8'h07, 8'h00, 45, 1'b0, 1'b0);
            for (int j = 36; j < 40; j++) begin
                total++;
                if (obs_tx[j] !== want_par) begin
                    bad++; $display("FAIL parity_bit inst=%0d t=%0d got=%b want=%b", inst, j, obs_tx[j], want_par);
                end
            end
            for (int j = 0; j < 45; j++) begin
                total++;
                if (obs_done[j] !== (j == 44)) begin
                    bad++; $display("FAIL parity_done inst=%0d t=%0d got=%b want=%b", inst, j, obs_done[j], (j == 44));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [2];
        logic [7:0] b [2];
        a[0] = 8'h00; b[0] = 8'hFF;
        a[1] = 8'($urandom); b[1] = 8'($urandom);
        for (int p = 0; p < 2; p++) begin
            drive_frame(0, a[p], b[p], 82, 1'b1, 1'b0);
            for (int j = 0; j < 82; j++) begin
                total++;
                if (obs_tx[j] !== exp_tx(0, a[p], b[p], j)) begin
                    bad++; $display("FAIL b2b_tx pair=%0d t=%0d got=%b want=%b", p, j, obs_tx[j], exp_tx(0, a[p], b[p], j));
                end
                total++;
                if (obs_done[j] !== exp_done(0, j)) begin
                    bad++; $display("FAIL b2b_done pair=%0d t=%0d got=%b want=%b", p, j, obs_done[j], exp_done(0, j));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'($urandom);
        @(negedge clk);
        s_data   = d;
        valid[0] = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            if (j == 0) valid[0] = 1'b0;
        end
        total++;
        if (tx_w[0] !== d[3]) begin bad++; $display("FAIL rstmid_bit3 got=%b want=%b", tx_w[0], d[3]); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (tx_w[0] !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx_w[0]); end
        total++;
        if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy_w[0]); end
        total++;
        if (rdy_w[0] !== 1'b0) begin bad++; $display("FAIL rstmid_ready_low got=%b want=0", rdy_w[0]); end
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy_w[0] !== 1'b1) begin bad++; $display("FAIL rstmid_ready_after got=%b want=1", rdy_w[0]); end
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            total++;
            if (done_w[0] !== 1'b0) begin bad++; $display("FAIL rstmid_nodone t=%0d got=%b want=0", j, done_w[0]); end
        end
        drive_frame(0, 8'h3C, 8'h00, 41, 1'b0, 1'b0);
        for (int j = 0; j <= 40; j++) begin
            total++;
            if (obs_tx[j] !== exp_tx(0, 8'h3C, 8'h00, j)) begin
                bad++; $display("FAIL rstmid_3c_tx t=%0d got=%b want=%b", j, obs_tx[j], exp_tx(0, 8'h3C, 8'h00, j));
            end
        end
        total++;
        if (obs_done[40] !== 1'b1) begin bad++; $display("FAIL rstmid_3c_done got=%b want=1", obs_done[40]); end
    endtask

    task automatic test_ignore_midframe();
        for (int r = 0; r < 3; r++) begin
            logic [7:0] d;
            d = 8'($urandom);
            drive_frame(0, d, 8'h00, 41, 1'b0, 1'b1);
            for (int j = 0; j <= 40; j++) begin
                total++;
                if (obs_tx[j] !== exp_tx(0, d, 8'h00, j)) begin
                    bad++; $display("FAIL ignore_tx d=%h t=%0d got=%b want=%b", d, j, obs_tx[j], exp_tx(0, d, 8'h00, j));
                end
                total++;
                if (obs_rdy[j] !== (j == 40)) begin
                    bad++; $display("FAIL ignore_ready t=%0d got=%b want=%b", j, obs_rdy[j], (j == 40));
                end
            end
        end
    endtask

    task automatic test_two_stop();
        logic [7:0] d;
        d = 8'($urandom);
        drive_frame(3, d, 8'h00, 23, 1'b0, 1'b0);
        for (int j = 18; j < 22; j++) begin
            total++;
            if (obs_tx[j] !== 1'b1) begin bad++; $display("FAIL stop2_level t=%0d got=%b want=1", j, obs_tx[j]); end
        end
        for (int j = 0; j < 23; j++) begin
            total++;
            if (obs_done[j] !== (j == 22)) begin
                bad++; $display("FAIL stop2_done t=%0d got=%b want=%b", j, obs_done[j], (j == 22));
            end
            total++;
            if (obs_tx[j] !== exp_tx(3, d, 8'h00, j)) begin
                bad++; $display("FAIL stop2_tx t=%0d got=%b want=%b", j, obs_tx[j], exp_tx(3, d, 8'h00, j));
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_random_frames();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        test_ignore_midframe();
        test_two_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_tx.md
USART_TX -- requirements
Module: usart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter BAUD_DIV, default 868, meaning clocks per serial bit; legal value >= 2.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop-bit count; legal values 1 or 2.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port s_rst_n_i, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port s_data_i, input, DATA_WIDTH bits: the word to transmit.
REQ-009 SHALL have port s_valid_i, input, 1 bit: s_data_i is valid.
REQ-010 SHALL have port s_ready_o, output, 1 bit: the block can accept a word.
REQ-011 SHALL have port tx_o, output, 1 bit: registered serial line, idle high.
REQ-012 SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when PARITY_EN=1.
REQ-015 SHALL drive s_ready_o = (state == IDLE) AND s_rst_n_i; busy_o = (state != IDLE).
REQ-016 SHALL accept a word only on an edge where s_valid_i=1 AND s_ready_o=1; at that edge: capture s_data_i, clear the baud counter, enter START, set tx_o to 0.
REQ-017 SHALL ignore s_valid_i and s_data_i outside IDLE; the captured word does not change mid-frame.
REQ-018 SHALL hold each bit (start, each data bit, parity, each stop bit) on tx_o for exactly BAUD_DIV clocks, timed by a baud counter running 0..BAUD_DIV-1 and wrapping to 0.
REQ-019 SHALL transmit data LSB first; a bit index counts 0..DATA_WIDTH-1 and leaves DATA after index DATA_WIDTH-1.
REQ-020 SHALL compute parity as XOR of the captured word for even parity and its inverse for odd parity.
REQ-021 SHALL drive tx_o=1 in STOP; after STOP_BITS x BAUD_DIV clocks it SHALL enter IDLE and pulse done_o for exactly 1 clock on that same edge.
REQ-022 SHALL give a frame length of (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) x BAUD_DIV clocks from the handshake edge to the done_o edge.
REQ-023 SHALL, with s_valid_i held high (back-to-back), accept the next word in the first IDLE cycle, so tx_o stays high for exactly 1 extra clock between frames.
REQ-024 SHALL size the baud counter at $clog2(BAUD_DIV) bits and the bit index at $clog2(DATA_WIDTH) bits, with no overflow at their maximum values.

Reset
REQ-025 SHALL, on any edge with s_rst_n_i=0, set state=IDLE, tx_o=1, done_o=0, baud counter=0, bit index=0 and shift register=0; a reset mid-frame aborts the frame with no done_o pulse.
REQ-026 SHALL hold s_ready_o=0 while s_rst_n_i=0 and SHALL drive s_ready_o=1 in the first cycle after release.

Verification (DATA_WIDTH=8, BAUD_DIV=4 unless stated)
REQ-027 SHALL cover: send 0xA5, no parity -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; done_o high 40 clocks after the handshake; busy_o high throughout.
REQ-028 SHALL cover: PARITY_EN=1 with 0x07 -> parity bit 1 for even and 0 for odd; frame length 44 clocks.
REQ-029 SHALL cover: s_valid_i held high with 0x00 then 0xFF -> second start bit follows exactly 1 idle-high clock after the first frame's done_o.
REQ-030 SHALL cover: s_rst_n_i=0 for 1 clock during data bit 3 -> tx_o=1 next clock, no done_o pulse, s_ready_o=1 after release, and a new 0x3C frame transmits correctly.
REQ-031 SHALL cover: s_data_i changes and s_valid_i toggles mid-frame -> s_ready_o=0 and the transmitted bits match the originally captured word.
REQ-032 SHALL cover: STOP_BITS=2, BAUD_DIV=2 -> stop level high for 4 clocks; done_o occurs 22 clocks after the handshake.
